// File: rtl/tca9539_master.sv
// I2C master for TCA9539 register transactions. It runs one command at a time: a 1/2-byte
// register write, or a pointer set followed by a 1/2-byte read. It returns read data and
// whether the slave NACKed any byte.
module tca9539_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        scl,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_oe_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [1:0]  cmd_addr_sel,
  input  logic [2:0]  cmd_reg,
  input  logic        cmd_len,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_nack,
  output logic [15:0] rsp_rdata,
  output logic        busy
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    StIdle, StStart, StTxByte, StAck, StRestart, StRxByte, StMack, StStop, StDone
  } state_e;

  state_e state_q, state_d;

  logic [DivW-1:0] div_q;
  logic [1:0]      qtr_q;
  logic [2:0]      bit_q;
  logic [2:0]      byte_q;   // 0 addr(w), 1 reg, 2 data0 / addr(r), 3 data1 / rx0, 4 rx1
  logic            lead_q;   // the cycle right after acceptance; the bus is still idle
  logic            rw_q;
  logic            len_q;
  logic [1:0]      addr_q;
  logic [2:0]      reg_q;
  logic [15:0]     wdata_q;
  logic            ack_q;    // sampled ACK bit, 1 = NACK
  logic            err_q;
  logic [15:0]     rdata_q;

  logic       accept;
  logic       ticking;
  logic       q_end;
  logic       sample;
  logic       slot_end;
  logic [2:0] last_idx;
  logic       last_byte;
  logic [7:0] tx_byte;

  assign accept    = cmd_valid && (state_q == StIdle);
  assign ticking   = (state_q != StIdle) && (state_q != StDone) && !lead_q;
  assign q_end     = ticking && (div_q == DivLast);
  assign sample    = q_end && (qtr_q == 2'd2);
  assign slot_end  = q_end && (qtr_q == 2'd3);
  assign last_idx  = rw_q ? (3'd3 + {2'b00, len_q}) : (3'd2 + {2'b00, len_q});
  assign last_byte = (byte_q == last_idx);

  // Byte to transmit for the current byte index
  always_comb begin
    tx_byte = 8'h00;
    case (byte_q)
      3'd0:    tx_byte = {5'b11101, addr_q, 1'b0};
      3'd1:    tx_byte = {5'b00000, reg_q};
      3'd2:    tx_byte = rw_q ? {5'b11101, addr_q, 1'b1} : wdata_q[7:0];
      3'd3:    tx_byte = wdata_q[15:8];
      default: tx_byte = 8'h00;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; every bus state advances only at the end of its slot
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = StStart;
      StStart:   if (slot_end) state_d = StTxByte;
      StTxByte:  if (slot_end && bit_q == 3'd7) state_d = StAck;
      StAck: begin
        if (slot_end) begin
          if (ack_q || last_byte)           state_d = StStop;
          else if (rw_q && byte_q == 3'd1)  state_d = StRestart;
          else if (rw_q && byte_q == 3'd2)  state_d = StRxByte;
          else                              state_d = StTxByte;
        end
      end
      StRestart: if (slot_end) state_d = StTxByte;
      StRxByte:  if (slot_end && bit_q == 3'd7) state_d = StMack;
      StMack:    if (slot_end) state_d = last_byte ? StStop : StRxByte;
      StStop:    if (slot_end) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Bus pin and handshake outputs decoded from state and quarter
  always_comb begin
    scl      = 1'b1;
    sda_oe_n = 1'b1;
    unique case (state_q)
      StStart: sda_oe_n = ~qtr_q[1];
      StTxByte: begin
        scl      = qtr_q[1];
        sda_oe_n = tx_byte[3'd7 - bit_q];
      end
      StAck, StRxByte: scl = qtr_q[1];
      StRestart: begin
        scl      = (qtr_q != 2'd0);
        sda_oe_n = ~qtr_q[1];
      end
      StMack: begin
        scl      = qtr_q[1];
        sda_oe_n = last_byte;
      end
      StStop: begin
        scl      = qtr_q[1];
        sda_oe_n = (qtr_q == 2'd3);
      end
      default: begin
        scl      = 1'b1;
        sda_oe_n = 1'b1;
      end
    endcase
  end

  assign sda_o     = 1'b0;
  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign rsp_valid = (state_q == StDone);

  // Command latch, slot timing counters, bit/byte indices and receive capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      lead_q  <= 1'b0;
      rw_q    <= 1'b0;
      len_q   <= 1'b0;
      addr_q  <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (accept) begin
      div_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      lead_q  <= 1'b1;
      rw_q    <= cmd_rw;
      len_q   <= cmd_len;
      addr_q  <= cmd_addr_sel;
      reg_q   <= cmd_reg;
      wdata_q <= cmd_wdata;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      lead_q <= 1'b0;
      if (ticking) begin
        div_q <= q_end ? '0 : div_q + DivW'(1);
        if (q_end) qtr_q <= qtr_q + 2'd1;
      end
      if (sample && state_q == StAck) ack_q <= sda_i;
      if (sample && state_q == StRxByte) rdata_q[{(byte_q == 3'd4), ~bit_q}] <= sda_i;
      if (slot_end) begin
        if (state_q == StTxByte || state_q == StRxByte) bit_q <= bit_q + 3'd1;
        if ((state_q == StAck || state_q == StMack) && state_d != StStop) begin
          byte_q <= byte_q + 3'd1;
        end
        if (state_q == StAck && ack_q) err_q <= 1'b1;
      end
    end
  end

  // Response registers, updated on entry to DONE and held until the next response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_nack  <= 1'b0;
      rsp_rdata <= '0;
    end else if (state_q == StStop && slot_end) begin
      rsp_nack  <= err_q;
      rsp_rdata <= err_q ? 16'h0000 : rdata_q;
    end
  end

endmodule

// File: tb/tb_tca9539_master.sv
// Bench for tca9539_master: behavioural TCA9539 slave on the bus, transaction-level reference
// model for expected responses and latency, and an SCL low-width monitor.
module tb_tca9539_master;
  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        scl, sda_i, sda_o, sda_oe_n;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0, cmd_len = 1'b0;
  logic [1:0]  cmd_addr_sel = 2'd0;
  logic [2:0]  cmd_reg = 3'd0;
  logic [15:0] cmd_wdata = 16'h0;
  logic        rsp_valid, rsp_nack, busy;
  logic [15:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tca9539_master #(.CLK_DIV(D)) dut (
    .clk(clk), .reset_n(reset_n), .scl(scl), .sda_i(sda_i), .sda_o(sda_o),
    .sda_oe_n(sda_oe_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr_sel(cmd_addr_sel), .cmd_reg(cmd_reg), .cmd_len(cmd_len),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_nack(rsp_nack),
    .rsp_rdata(rsp_rdata), .busy(busy)
  );

  // Slave model state
  logic        slv_sda = 1'b1;
  logic [7:0]  s_regs [8];
  logic [15:0] io_in = 16'h0;
  logic [1:0]  slave_addr = 2'd1;
  logic        p_scl = 1'b1, p_sda = 1'b1, cur_scl, cur_sda;
  logic        s_active = 1'b0, s_skip = 1'b0, s_tx = 1'b0, s_rd = 1'b0, s_mnack = 1'b0;
  logic        s_ack;
  logic [7:0]  s_shift = 8'h0, s_out = 8'h0;
  logic [2:0]  s_ptr = 3'd0;
  int          s_bitcnt = 0, s_byte = 0;
  int          start_cnt = 0, stop_cnt = 0, short_lows = 0, low_len = 0;
  bit          mon_en = 1'b1;

  // Reference model state and expectations
  logic [7:0]  ref_regs [8];
  logic [7:0]  save_regs [8];
  logic        e_nack;
  logic [15:0] e_rdata;
  int          e_slots, e_starts;

  assign sda_i = sda_oe_n & slv_sda;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] slave_val(input logic [2:0] p);
    if (p == 3'd0) return io_in[7:0] ^ s_regs[4];
    if (p == 3'd1) return io_in[15:8] ^ s_regs[5];
    return s_regs[p];
  endfunction

  // Behavioural TCA9539 slave, evaluated on falling clk edges
  initial begin
    s_regs = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
    forever begin
      @(negedge clk);
      cur_scl = scl;
      cur_sda = sda_i;
      if (p_scl && cur_scl && p_sda && !cur_sda) begin
        start_cnt++;
        s_active = 1; s_skip = 1; s_tx = 0; s_rd = 0; s_bitcnt = 0; s_byte = 0; slv_sda = 1;
      end else if (p_scl && cur_scl && !p_sda && cur_sda) begin
        stop_cnt++;
        s_active = 0; slv_sda = 1;
      end else if (s_active && !p_scl && cur_scl) begin
        if (s_bitcnt < 8) begin
          if (!s_tx) s_shift = {s_shift[6:0], cur_sda};
        end else if (s_tx) begin
          s_mnack = cur_sda;
        end
      end else if (s_active && p_scl && !cur_scl) begin
        if (s_skip) begin
          s_skip = 0;
        end else if (s_bitcnt < 8) begin
          s_bitcnt++;
          if (s_bitcnt == 8) begin
            if (s_tx) begin
              slv_sda = 1;
            end else begin
              s_ack = 1;
              if (s_byte == 0) begin
                s_ack = (s_shift[7:1] == {5'b11101, slave_addr});
                s_rd = s_shift[0];
              end else if (s_byte == 1) begin
                s_ptr = s_shift[2:0];
              end else begin
                if (s_ptr >= 3'd2) s_regs[s_ptr] = s_shift;
                s_ptr = s_ptr ^ 3'd1;
              end
              s_byte++;
              slv_sda = s_ack ? 1'b0 : 1'b1;
              if (!s_ack) s_active = 0;
            end
          end else if (s_tx) begin
            slv_sda = s_out[7 - s_bitcnt];
          end
        end else begin
          s_bitcnt = 0;
          if (s_tx) begin
            if (s_mnack) begin
              s_active = 0; slv_sda = 1;
            end else begin
              s_out = slave_val(s_ptr); s_ptr = s_ptr ^ 3'd1; slv_sda = s_out[7];
            end
          end else if (s_rd) begin
            s_tx = 1; s_out = slave_val(s_ptr); s_ptr = s_ptr ^ 3'd1; slv_sda = s_out[7];
          end else begin
            slv_sda = 1;
          end
        end
      end
      p_scl = cur_scl;
      p_sda = cur_sda;
    end
  end

  // SCL low phases must be 2*D cycles, or D for the low quarter that opens a RESTART
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        low_len = 0;
      end else if (!scl) begin
        low_len++;
      end else if (low_len != 0) begin
        if (low_len == D) short_lows++;
        chk("scl_low_width", 64'(low_len == D || low_len == 2 * D), 64'd1);
        low_len = 0;
      end
    end
  end

  function automatic logic [7:0] ref_val(input logic [2:0] r);
    if (r < 3'd2) return (r == 3'd0 ? io_in[7:0] : io_in[15:8]) ^ ref_regs[4 + r];
    return ref_regs[r];
  endfunction

  // Transaction-level expectation: slot count from byte counts, data from register semantics
  task automatic ref_cmd(input logic rw, input logic [1:0] asel, input logic [2:0] r,
                         input logic len, input logic [15:0] wd);
    e_nack = (asel != slave_addr);
    e_rdata = 16'h0;
    e_starts = 1;
    if (e_nack) begin
      e_slots = 11;
    end else if (!rw) begin
      e_slots = 1 + 9 * (3 + int'(len)) + 1;
      if (r >= 3'd2) ref_regs[r] = wd[7:0];
      if (len && (r ^ 3'd1) >= 3'd2) ref_regs[r ^ 3'd1] = wd[15:8];
    end else begin
      e_slots = 1 + 9 * 2 + 1 + 9 * (2 + int'(len)) + 1;
      e_starts = 2;
      e_rdata[7:0] = ref_val(r);
      if (len) e_rdata[15:8] = ref_val(r ^ 3'd1);
    end
  endtask

  task automatic accepted(input logic rw, input logic [1:0] asel, input logic [2:0] r,
                          input logic len, input logic [15:0] wd, input bit hold);
    start_cnt = 0; stop_cnt = 0; short_lows = 0;
    ref_cmd(rw, asel, r, len, wd);
    if (!hold) begin
      cmd_valid = 0;
      cmd_rw = 1'($urandom); cmd_addr_sel = 2'($urandom); cmd_reg = 3'($urandom);
      cmd_len = 1'($urandom); cmd_wdata = 16'($urandom);
    end
  endtask

  task automatic issue(input logic rw, input logic [1:0] asel, input logic [2:0] r,
                       input logic len, input logic [15:0] wd, input bit hold);
    int n;
    @(negedge clk);
    cmd_rw = rw; cmd_addr_sel = asel; cmd_reg = r; cmd_len = len; cmd_wdata = wd;
    cmd_valid = 1;
    n = 0;
    while (!cmd_ready && n < 4 * D * 60) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    accepted(rw, asel, r, len, wd, hold);
  endtask

  function automatic logic [47:0] pack_s();
    return {s_regs[7], s_regs[6], s_regs[5], s_regs[4], s_regs[3], s_regs[2]};
  endfunction

  function automatic logic [47:0] pack_r();
    return {ref_regs[7], ref_regs[6], ref_regs[5], ref_regs[4], ref_regs[3], ref_regs[2]};
  endfunction

  task automatic wait_rsp(input string tag);
    int cyc = 0;
    while (!rsp_valid && cyc < 4 * D * 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(4 * D * e_slots + 1));
    chk({tag, "_nack"}, 64'(rsp_nack), 64'(e_nack));
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(e_rdata));
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    @(posedge clk); #1;
    chk({tag, "_after"}, 64'({rsp_valid, cmd_ready, busy}), 64'(3'b010));
    chk({tag, "_hold"}, 64'({rsp_nack, rsp_rdata}), 64'({e_nack, e_rdata}));
    chk({tag, "_starts"}, 64'(start_cnt), 64'(e_starts));
    chk({tag, "_stops"}, 64'(stop_cnt), 64'd1);
    chk({tag, "_restart_low"}, 64'(short_lows), 64'(e_starts - 1));
    chk({tag, "_regs"}, 64'(pack_s()), 64'(pack_r()));
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic        r_rw, r_len;
    logic [1:0]  r_asel;
    logic [2:0]  r_reg;
    logic [15:0] r_wd;
    ref_regs = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};

    #1 reset_n = 0;
    #1;
    chk("reset_pins", 64'({scl, sda_oe_n, sda_o}), 64'(3'b110));
    chk("reset_hs", 64'({cmd_ready, busy, rsp_valid}), 64'(3'b100));
    chk("reset_rsp", 64'({rsp_nack, rsp_rdata}), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1;

    // Single-byte write
    issue(0, 2'd1, 3'd2, 0, 16'h00A5, 0);
    wait_rsp("wr1");
    chk("wr1_outport0", 64'(s_regs[2]), 64'h00A5);

    // Config write, then 1- and 2-byte reads of the input port
    issue(0, 2'd1, 3'd6, 0, 16'h0000, 0);
    wait_rsp("wr_cfg");
    io_in = 16'h3C5A;
    issue(1, 2'd1, 3'd0, 0, 16'h0, 0);
    wait_rsp("rd1");
    chk("rd1_value", 64'(rsp_rdata), 64'h005A);
    issue(1, 2'd1, 3'd0, 1, 16'h0, 0);
    wait_rsp("rd2");

    // Address NACK with the slave strapped elsewhere
    slave_addr = 2'd2;
    issue(1, 2'd1, 3'd0, 0, 16'h0, 0);
    wait_rsp("nack");
    slave_addr = 2'd1;

    // Two queued commands with cmd_valid held high
    issue(0, 2'd1, 3'd6, 1, 16'h1234, 1);
    cmd_rw = 1; cmd_addr_sel = 2'd1; cmd_reg = 3'd6; cmd_len = 1; cmd_wdata = 16'hBEEF;
    wait_rsp("q1");
    @(posedge clk); #1;
    chk("q2_accept", 64'({busy, cmd_ready}), 64'(2'b10));
    accepted(1, 2'd1, 3'd6, 1, 16'hBEEF, 0);
    wait_rsp("q2");

    // Reset during bit 4 of the data byte of a write
    for (int i = 0; i < 8; i++) save_regs[i] = ref_regs[i];
    issue(0, 2'd1, 3'd3, 0, 16'h0077, 0);
    repeat (1 + 23 * 4 * D + D) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 64'd1);
    mon_en = 0;
    reset_n = 0;
    #1;
    chk("rst_mid_pins", 64'({scl, sda_oe_n}), 64'(2'b11));
    chk("rst_mid_hs", 64'({cmd_ready, busy, rsp_valid}), 64'(3'b100));
    for (int i = 0; i < 8; i++) ref_regs[i] = save_regs[i];
    repeat (3) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    mon_en = 1;
    issue(0, 2'd1, 3'd3, 0, 16'h005A, 0);
    wait_rsp("post_rst");

    // Randomized commands against the reference model
    for (int i = 0; i < 14; i++) begin
      io_in = 16'($urandom);
      r_rw = 1'($urandom);
      r_len = 1'($urandom);
      r_reg = 3'($urandom);
      r_wd = 16'($urandom);
      r_asel = ($urandom_range(0, 4) == 0) ? 2'($urandom) : slave_addr;
      issue(r_rw, r_asel, r_reg, r_len, r_wd, 0);
      wait_rsp("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
